// File: rtl/cpu_pkg.sv
// Shared encodings for the myCPU core: load types, MEM/WB FSM states, reset PC.
package cpu_pkg;

   localparam logic [2:0] LT_LB  = 3'd0;
   localparam logic [2:0] LT_LBU = 3'd1;
   localparam logic [2:0] LT_LH  = 3'd2;
   localparam logic [2:0] LT_LHU = 3'd3;
   localparam logic [2:0] LT_LW  = 3'd4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load return and sign/zero extends it.
module load_align
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = 2
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [LANE_W-1:0] lane,
   input  logic [2:0]        load_type,
   output logic [DATA_W-1:0] result
);

   logic [LANE_W-1:0] w_hlane;
   logic [DATA_W-1:0] w_bsh;
   logic [DATA_W-1:0] w_hsh;

   // Halfword accesses drop the lane LSB; a misaligned address already trapped upstream.
   assign w_hlane = lane & ~LANE_W'(1);
   assign w_bsh   = rdata >> {lane, 3'b000};
   assign w_hsh   = rdata >> {w_hlane, 3'b000};

   always_comb begin
      result = rdata;
      case (load_type)
         LT_LB:   result = {{(DATA_W-8){w_bsh[7]}}, w_bsh[7:0]};
         LT_LBU:  result = {{(DATA_W-8){1'b0}}, w_bsh[7:0]};
         LT_LH:   result = {{(DATA_W-16){w_hsh[15]}}, w_hsh[15:0]};
         LT_LHU:  result = {{(DATA_W-16){1'b0}}, w_hsh[15:0]};
         LT_LW:   result = rdata;
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: holds the stage while a data-SRAM read is outstanding,
// aligns the load return and presents qualified writeback controls to WB.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int               DATA_W   = 32,
   parameter int               REG_AW   = 5,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT),
   parameter bit               HILO_EN  = 1'b1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_pc,
   input  logic [DATA_W-1:0]   in_aluout,
   input  logic [REG_AW-1:0]   in_writereg,
   input  logic                in_regwrite,
   input  logic                in_memtoreg,
   input  logic [2:0]          in_load_type,
   input  logic                in_hilo_write,
   input  logic [2*DATA_W-1:0] in_hilo,
   input  logic                stall,
   input  logic                flush,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_data_ok,
   output logic                stall_req,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_pc,
   output logic [DATA_W-1:0]   out_result,
   output logic [REG_AW-1:0]   out_writereg,
   output logic                out_regwrite,
   output logic                out_hilo_write,
   output logic [2*DATA_W-1:0] out_hilo,
   output logic [1:0]          dbg_state
);

   localparam int LANE_W = (DATA_W > 8) ? $clog2(DATA_W/8) : 1;

   logic [1:0]        r_state;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_aluout;
   logic [REG_AW-1:0] r_writereg;
   logic              r_regwrite;
   logic              r_memtoreg;
   logic [2:0]        r_load_type;
   logic [DATA_W-1:0] r_rdata;

   logic              w_capture;
   logic              w_out_valid;
   logic [DATA_W-1:0] w_aligned;

   assign w_capture = (r_state == ST_IDLE) && !flush && !stall;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_valid     <= 1'b0;
         r_pc        <= RESET_PC;
         r_aluout    <= '0;
         r_writereg  <= '0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_load_type <= '0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  r_valid <= 1'b0;
               end else if (!stall) begin
                  r_valid     <= in_valid;
                  r_pc        <= in_pc;
                  r_aluout    <= in_aluout;
                  r_writereg  <= in_writereg;
                  r_regwrite  <= in_regwrite;
                  r_memtoreg  <= in_memtoreg;
                  r_load_type <= in_load_type;
                  if (in_valid && in_memtoreg) r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_data_ok) begin
                  r_rdata <= mem_rdata;
                  r_state <= ST_IDLE;
                  if (flush) r_valid <= 1'b0;
               end else if (flush) begin
                  r_valid <= 1'b0;
                  r_state <= ST_DRAIN;
               end
            end
            // A flushed load still owns the SRAM response; swallow it before accepting more.
            ST_DRAIN: begin
               if (mem_data_ok) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   load_align #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_load_align (
      .rdata     (r_rdata),
      .lane      (r_aluout[LANE_W-1:0]),
      .load_type (r_load_type),
      .result    (w_aligned)
   );

   assign w_out_valid  = r_valid && (r_state == ST_IDLE);
   assign stall_req    = (r_state != ST_IDLE);
   assign out_valid    = w_out_valid;
   assign out_pc       = r_pc;
   assign out_result   = r_memtoreg ? w_aligned : r_aluout;
   assign out_writereg = r_writereg;
   assign out_regwrite = w_out_valid && r_regwrite;
   assign dbg_state    = r_state;

   generate
      if (HILO_EN) begin : g_hilo
         logic                r_hilo_write;
         logic [2*DATA_W-1:0] r_hilo;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_hilo_write <= 1'b0;
               r_hilo       <= '0;
            end else if (w_capture) begin
               r_hilo_write <= in_hilo_write;
               r_hilo       <= in_hilo;
            end
         end

         assign out_hilo_write = w_out_valid && r_hilo_write;
         assign out_hilo       = r_hilo;
      end else begin : g_no_hilo
         assign out_hilo_write = 1'b0;
         assign out_hilo       = '0;
      end
   endgenerate

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for ALU/load results plus hand sequences
// for load latency, stall/flush, drain and reset during an outstanding load.
module tb_mem_wb_stage;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_aluout;
   logic [4:0]  in_writereg;
   logic        in_regwrite;
   logic        in_memtoreg;
   logic [2:0]  in_load_type;
   logic        in_hilo_write;
   logic [63:0] in_hilo;
   logic        stall;
   logic        flush;
   logic [31:0] mem_rdata;
   logic        mem_data_ok;
   logic        stall_req;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_result;
   logic [4:0]  out_writereg;
   logic        out_regwrite;
   logic        out_hilo_write;
   logic [63:0] out_hilo;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic allow_stray = 1'b0;

   mem_wb_stage dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_pc(in_pc), .in_aluout(in_aluout),
      .in_writereg(in_writereg), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
      .in_load_type(in_load_type), .in_hilo_write(in_hilo_write), .in_hilo(in_hilo),
      .stall(stall), .flush(flush), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok),
      .stall_req(stall_req), .out_valid(out_valid), .out_pc(out_pc),
      .out_result(out_result), .out_writereg(out_writereg), .out_regwrite(out_regwrite),
      .out_hilo_write(out_hilo_write), .out_hilo(out_hilo), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A read return with no load outstanding indicates a protocol error upstream.
   always @(posedge clk) begin
      if (resetn && mem_data_ok && dbg_state == 2'd0 && !allow_stray) begin
         errors++;
         $display("FAIL stray_data_ok: data_ok=%0d in state %0d, required none", mem_data_ok, dbg_state);
      end
   end

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] aluout;
      logic [4:0]  writereg;
      logic        regwrite;
      logic        memtoreg;
      logic [2:0]  load_type;
      logic        hilo_write;
      logic [63:0] hilo;
      logic [31:0] rdata;
      logic        exp_valid;
      logic [31:0] exp_result;
      logic        exp_regwrite;
      logic        exp_hilo_write;
   } vec_t;

   vec_t vecs[12];

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      in_valid = 0; in_pc = 0; in_aluout = 0; in_writereg = 0; in_regwrite = 0;
      in_memtoreg = 0; in_load_type = 0; in_hilo_write = 0; in_hilo = 0;
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                              input logic rw, input logic m2r, input logic [2:0] lt);
      in_valid = 1; in_pc = pc; in_aluout = alu; in_writereg = rd; in_regwrite = rw;
      in_memtoreg = m2r; in_load_type = lt; in_hilo_write = 0; in_hilo = 0;
   endtask

   // ---------------- test ----------------
   initial begin
      int stall_cnt;
      vecs[0]  = '{1, 32'h100, 32'h0000_1234,  8, 1, 0, 3'd0, 0, 64'h0, 32'h0,          1, 32'h0000_1234, 1, 0};
      vecs[1]  = '{1, 32'h104, 32'hABCD_0000,  0, 0, 0, 3'd0, 1, 64'h1111_2222_3333_4444, 32'h0, 1, 32'hABCD_0000, 0, 1};
      vecs[2]  = '{0, 32'h108, 32'h0000_0077,  9, 1, 0, 3'd0, 0, 64'h0, 32'h0,          0, 32'h0000_0077, 0, 0};
      vecs[3]  = '{1, 32'h10C, 32'h0000_1000, 10, 1, 1, 3'd0, 0, 64'h0, 32'h1234_5678, 1, 32'h0000_0078, 1, 0};
      vecs[4]  = '{1, 32'h110, 32'h0000_1001, 11, 1, 1, 3'd0, 0, 64'h0, 32'h0000_8000, 1, 32'hFFFF_FF80, 1, 0};
      vecs[5]  = '{1, 32'h114, 32'h0000_1003, 12, 1, 1, 3'd1, 0, 64'h0, 32'hA500_0000, 1, 32'h0000_00A5, 1, 0};
      vecs[6]  = '{1, 32'h118, 32'h0000_2000, 13, 1, 1, 3'd2, 0, 64'h0, 32'h0000_8001, 1, 32'hFFFF_8001, 1, 0};
      vecs[7]  = '{1, 32'h11C, 32'h0000_2002, 14, 1, 1, 3'd2, 0, 64'h0, 32'h7FFF_0000, 1, 32'h0000_7FFF, 1, 0};
      vecs[8]  = '{1, 32'h120, 32'h0000_2002, 15, 1, 1, 3'd3, 0, 64'h0, 32'hBEEF_0000, 1, 32'h0000_BEEF, 1, 0};
      vecs[9]  = '{1, 32'h124, 32'h0000_3000, 16, 1, 1, 3'd4, 0, 64'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 0};
      vecs[10] = '{1, 32'h128, 32'h0000_2003, 17, 1, 1, 3'd2, 0, 64'h0, 32'hC0DE_1234, 1, 32'hFFFF_C0DE, 1, 0};
      vecs[11] = '{1, 32'h12C, 32'h0000_1002, 18, 1, 1, 3'd0, 0, 64'h0, 32'h0042_0000, 1, 32'h0000_0042, 1, 0};

      resetn = 0; stall = 0; flush = 0; mem_rdata = 0; mem_data_ok = 0;
      drive_idle();
      repeat (2) @(negedge clk);
      check("rst_valid",      out_valid, 0);
      check("rst_pc",         out_pc, 32'hbfc00000);
      check("rst_stall_req",  stall_req, 0);
      check("rst_result",     out_result, 0);
      check("rst_regwrite",   out_regwrite, 0);
      check("rst_hilo_write", out_hilo_write, 0);
      resetn = 1;
      @(negedge clk);

      // Vector table: each entry is one instruction; loads get their return one cycle later.
      for (int i = 0; i < 12; i++) begin
         in_valid = vecs[i].valid; in_pc = vecs[i].pc; in_aluout = vecs[i].aluout;
         in_writereg = vecs[i].writereg; in_regwrite = vecs[i].regwrite;
         in_memtoreg = vecs[i].memtoreg; in_load_type = vecs[i].load_type;
         in_hilo_write = vecs[i].hilo_write; in_hilo = vecs[i].hilo;
         step();
         if (vecs[i].valid && vecs[i].memtoreg) begin
            check($sformatf("v%0d_wait_stall", i), stall_req, 1);
            check($sformatf("v%0d_wait_valid", i), out_valid, 0);
            mem_rdata = vecs[i].rdata; mem_data_ok = 1;
            step();
            mem_data_ok = 0; mem_rdata = 0;
         end
         check($sformatf("v%0d_stall_req", i),  stall_req, 0);
         check($sformatf("v%0d_valid", i),      out_valid, vecs[i].exp_valid);
         check($sformatf("v%0d_result", i),     out_result, vecs[i].exp_result);
         check($sformatf("v%0d_regwrite", i),   out_regwrite, vecs[i].exp_regwrite);
         check($sformatf("v%0d_writereg", i),   out_writereg, vecs[i].writereg);
         check($sformatf("v%0d_pc", i),         out_pc, vecs[i].pc);
         check($sformatf("v%0d_hilo_write", i), out_hilo_write, vecs[i].exp_hilo_write);
         if (vecs[i].exp_hilo_write) check($sformatf("v%0d_hilo", i), out_hilo, vecs[i].hilo);
      end

      // LB lane 3 with a 3-cycle gap before data_ok: stall_req must be high 4 cycles.
      drive_instr(32'h200, 32'h0000_1003, 5'd20, 1, 1, 3'd0);
      step();
      drive_idle();
      stall_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         if (stall_req) stall_cnt++;
         step();
      end
      mem_rdata = 32'h80FF_0000; mem_data_ok = 1;
      if (stall_req) stall_cnt++;
      step();
      mem_data_ok = 0; mem_rdata = 0;
      check("lb_stall_cycles", stall_cnt, 4);
      check("lb_stall_clear",  stall_req, 0);
      check("lb_valid",        out_valid, 1);
      check("lb_result",       out_result, 32'hFFFF_FF80);

      // Stall holds the stage; stall together with flush invalidates it.
      drive_instr(32'h300, 32'h0000_5555, 5'd3, 1, 0, 3'd0);
      step();
      check("pre_stall_result", out_result, 32'h0000_5555);
      stall = 1;
      drive_instr(32'h304, 32'h0000_6666, 5'd4, 1, 0, 3'd0);
      step();
      check("stall_result",   out_result, 32'h0000_5555);
      check("stall_writereg", out_writereg, 5'd3);
      check("stall_pc",       out_pc, 32'h300);
      check("stall_valid",    out_valid, 1);
      flush = 1;
      step();
      check("stall_flush_valid",    out_valid, 0);
      check("stall_flush_regwrite", out_regwrite, 0);
      stall = 0; flush = 0;
      drive_idle();
      step();

      // Flush while a load is outstanding: drain the response, never write back.
      drive_instr(32'h400, 32'h0000_1000, 5'd21, 1, 1, 3'd4);
      step();
      drive_idle();
      flush = 1;
      step();
      flush = 0;
      check("drain_stall",    stall_req, 1);
      check("drain_valid",    out_valid, 0);
      check("drain_regwrite", out_regwrite, 0);
      step();
      check("drain_hold", stall_req, 1);
      mem_rdata = 32'h1111_1111; mem_data_ok = 1;
      step();
      mem_data_ok = 0; mem_rdata = 0;
      check("drain_done_stall",    stall_req, 0);
      check("drain_done_valid",    out_valid, 0);
      check("drain_done_regwrite", out_regwrite, 0);
      drive_instr(32'h404, 32'h0000_0ACE, 5'd7, 1, 0, 3'd0);
      step();
      drive_idle();
      check("post_drain_result", out_result, 32'h0000_0ACE);
      check("post_drain_valid",  out_valid, 1);

      // Flush coinciding with data_ok: back to IDLE, result dropped.
      drive_instr(32'h500, 32'h0000_1000, 5'd22, 1, 1, 3'd4);
      step();
      drive_idle();
      flush = 1; mem_rdata = 32'h2222_2222; mem_data_ok = 1;
      step();
      flush = 0; mem_data_ok = 0; mem_rdata = 0;
      check("flush_ok_stall",    stall_req, 0);
      check("flush_ok_regwrite", out_regwrite, 0);

      // Asynchronous reset during WAIT, then a stray data_ok that must be ignored.
      drive_instr(32'h600, 32'h0000_1000, 5'd23, 1, 1, 3'd4);
      step();
      drive_idle();
      check("rwait_stall", stall_req, 1);
      #2 resetn = 0;
      #1;
      check("rwait_pc",    out_pc, 32'hbfc00000);
      check("rwait_stall_clear", stall_req, 0);
      check("rwait_valid", out_valid, 0);
      @(negedge clk);
      resetn = 1;
      allow_stray = 1; mem_rdata = 32'h3333_3333; mem_data_ok = 1;
      step();
      mem_data_ok = 0; mem_rdata = 0; allow_stray = 0;
      check("stray_valid",    out_valid, 0);
      check("stray_stall",    stall_req, 0);
      check("stray_result",   out_result, 0);
      check("stray_regwrite", out_regwrite, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
